// File: rtl/sample_tx_stream.sv
// rtl/sample_tx_stream.sv - dmem-snooping UART transmitter with a 32-bit word FIFO
//
// Purpose: watches processor data-memory stores. Words stored to TX_ADDR are
// queued and sent LSB byte first as UART frames (8N1). Stores to CTRL_ADDR
// clear the sticky overflow flag (data[0]) and/or flush the queue (data[1]).
// Optional build macro SAMPLE_TX_PARITY_EN adds an even-parity bit per byte
// (8E1) and sets status[12].
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   wren         in   processor dmem write enable
//   address_dmem in   processor dmem word address [11:0]
//   data         in   processor store data [31:0]
//   tx           out  UART serial line, idle high
//   status       out  {count, full, empty, busy, overflow, parity_en}, registered
//   fifo_full    out  queue full, combinational from the pointers
module sample_tx_stream #(
  parameter int          CLKS_PER_BIT   = 434,
  parameter logic [11:0] TX_ADDR        = 12'hC80,
  parameter logic [11:0] CTRL_ADDR      = 12'hC81,
  parameter int          FIFO_DEPTH     = 8,
  parameter int          BYTES_PER_WORD = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wren,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  output logic        tx,
  output logic [31:0] status,
  output logic        fifo_full
);

  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0]       LAST_BYTE  = 2'(BYTES_PER_WORD - 1);
`ifdef SAMPLE_TX_PARITY_EN
  localparam logic PARITY_FLAG = 1'b1;
`else
  localparam logic PARITY_FLAG = 1'b0;
`endif
  localparam logic [31:0] STATUS_RESET = {19'd0, PARITY_FLAG, 12'h200};

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SAMPLE_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t state, state_next;

  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push_req;
  logic             ctrl_req;
  logic             push;
  logic             pop;
  logic             flush;
  logic             ovf_clear;
  logic             overflow;
  logic [31:0]      word_reg;
  logic [1:0]       byte_idx;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] clk_cnt;
  logic             bit_done;
  logic [7:0]       cur_byte;
  logic [31:0]      status_reg;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                     (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign count     = wr_ptr - rd_ptr;
  assign fifo_full = full;

  assign push_req  = wren && (address_dmem == TX_ADDR);
  assign ctrl_req  = wren && (address_dmem == CTRL_ADDR);
  assign push      = push_req && !full;
  assign flush     = ctrl_req && data[1];
  assign ovf_clear = ctrl_req && data[0];

  assign bit_done  = (clk_cnt == '0);
  assign cur_byte  = 8'(word_reg >> {byte_idx, 3'b000});
  assign status    = status_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (!empty) state_next = S_START;
      S_START: if (bit_done) state_next = S_DATA;
      S_DATA: begin
        if (bit_done && bit_idx == 3'd7) begin
`ifdef SAMPLE_TX_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef SAMPLE_TX_PARITY_EN
      S_PARITY: if (bit_done) state_next = S_STOP;
`endif
      S_STOP: begin
        // Remaining bytes of the same word follow with no idle gap.
        if (bit_done) state_next = (byte_idx < LAST_BYTE) ? S_START : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // tx is decoded from state so an asynchronous reset forces the line high at once.
  always_comb begin
    tx  = 1'b1;
    pop = 1'b0;
    case (state)
      S_IDLE:   pop = !empty;
      S_START:  tx  = 1'b0;
      S_DATA:   tx  = cur_byte[bit_idx];
`ifdef SAMPLE_TX_PARITY_EN
      S_PARITY: tx  = ^cur_byte;
`endif
      default:  tx  = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[IDX_W-1:0]] <= data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      word_reg   <= '0;
      byte_idx   <= '0;
      bit_idx    <= '0;
      clk_cnt    <= CNT_RELOAD;
      status_reg <= STATUS_RESET;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;

      // Flush discards queued words only; the word already in word_reg finishes.
      if (flush)    rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + 1'b1;

      // Full is judged before the edge, so a same-edge pop does not make room.
      if (push_req && full) overflow <= 1'b1;
      else if (ovf_clear)   overflow <= 1'b0;

      if (pop) word_reg <= mem[rd_ptr[IDX_W-1:0]];

      if (pop) begin
        byte_idx <= '0;
      end else if (state == S_STOP && bit_done && byte_idx < LAST_BYTE) begin
        byte_idx <= byte_idx + 2'd1;
      end

      // Wraps 7 -> 0 at the last data bit, ready for the next byte.
      if (state == S_DATA && bit_done) bit_idx <= bit_idx + 3'd1;

      if (state == S_IDLE || bit_done) clk_cnt <= CNT_RELOAD;
      else                             clk_cnt <= clk_cnt - 1'b1;

      status_reg <= {19'd0, PARITY_FLAG, overflow, (state != S_IDLE),
                     empty, full, 8'(count)};
    end
  end

endmodule

// File: tb/tb_sample_tx_stream.sv
// tb/tb_sample_tx_stream.sv - directed self-checking bench for sample_tx_stream
module tb_sample_tx_stream;

  localparam int CPB = 4;
  localparam logic [11:0] A_TX   = 12'hC80;
  localparam logic [11:0] A_CTRL = 12'hC81;
`ifdef SAMPLE_TX_PARITY_EN
  localparam int FB = 11;
  localparam logic [31:0] STAT_PAR = 32'h0000_1000;
`else
  localparam int FB = 10;
  localparam logic [31:0] STAT_PAR = 32'h0000_0000;
`endif
  localparam int WB = 2 * FB;
  localparam logic [31:0] STAT_IDLE = STAT_PAR | 32'h0000_0200;

  logic        clock;
  logic        reset;
  logic        wren;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        tx;
  logic [31:0] status;
  logic        fifo_full;

  int n_checks = 0;
  int n_errors = 0;

  sample_tx_stream #(
    .CLKS_PER_BIT(CPB),
    .TX_ADDR(A_TX),
    .CTRL_ADDR(A_CTRL),
    .FIFO_DEPTH(8),
    .BYTES_PER_WORD(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .wren(wren),
    .address_dmem(address_dmem),
    .data(data),
    .tx(tx),
    .status(status),
    .fifo_full(fifo_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic store(input logic [11:0] addr, input logic [31:0] value);
    @(negedge clock);
    wren = 1'b1;
    address_dmem = addr;
    data = value;
    @(negedge clock);
    wren = 1'b0;
  endtask

  // Line frame of one byte, bit 0 = start bit.
  function automatic logic [10:0] frame(input logic [7:0] b);
`ifdef SAMPLE_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b0, 1'b1, b, 1'b0};
`endif
  endfunction

  function automatic logic [31:0] word_frame(input logic [7:0] b1, input logic [7:0] b0);
    logic [31:0] w;
    w = (32'(frame(b1)) << FB) | 32'(frame(b0));
    return w;
  endfunction

  // Waits for a start bit, then samples nbits in the middle of each bit cell.
  task automatic rx_word(input int nbits, output logic [31:0] got);
    int t;
    got = '0;
    t = 0;
    while (tx !== 1'b0 && t < 400) begin
      @(negedge clock);
      t++;
    end
    check("rx_start_seen", {31'd0, tx === 1'b0}, 32'd1);
    @(negedge clock);
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) repeat (CPB) @(negedge clock);
      got[i] = tx;
    end
  endtask

  task automatic count_tx_low(input int cycles, output int lows);
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (tx !== 1'b1) lows++;
    end
  endtask

  logic [31:0] got;
  logic [31:0] exp_w;
  int lows;
  int t;

  initial begin
    reset = 1'b0;
    wren = 1'b0;
    address_dmem = '0;
    data = '0;
    repeat (3) @(negedge clock);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_status", status, STAT_IDLE);
    check("reset_full", {31'd0, fifo_full}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Single word 0xA53C: latency, bit order, busy drop afterwards.
    store(A_TX, 32'h0000_A53C);
    @(negedge clock);
    check("first_edge_start", {31'd0, tx}, 32'd0);
    rx_word(WB, got);
`ifdef SAMPLE_TX_PARITY_EN
    exp_w = 32'({1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0});
`else
    exp_w = 32'({1'b1, 8'hA5, 1'b0, 1'b1, 8'h3C, 1'b0});
`endif
    check("single_word_line", got, exp_w);
    repeat (CPB) @(negedge clock);
    check("single_word_idle", status, STAT_IDLE);

    // Fill and overflow while a word is on the line.
    store(A_TX, 32'h0000_0011);
    repeat (2) @(negedge clock);
    for (int i = 0; i < 9; i++) begin
      wren = 1'b1;
      address_dmem = A_TX;
      data = 32'h100 + 32'(i);
      @(negedge clock);
    end
    wren = 1'b0;
    check("fill_full_flag", {31'd0, fifo_full}, 32'd1);
    @(negedge clock);
    check("fill_status", status, STAT_PAR | 32'h0000_0D08);

    // Clear overflow and flush; in-flight word still completes.
    store(A_CTRL, 32'h0000_0003);
    @(negedge clock);
    check("flush_status", status, STAT_PAR | 32'h0000_0600);
    check("flush_full_flag", {31'd0, fifo_full}, 32'd0);
    t = 0;
    while (status[10] && t < 300) begin
      @(negedge clock);
      t++;
    end
    check("flush_idle_status", status, STAT_IDLE);
    count_tx_low(4 * WB, lows);
    check("flush_no_more_tx", 32'(lows), 32'd0);

    // Stores to neighbouring addresses are ignored.
    store(12'hC7F, 32'h0000_00FF);
    store(12'hC82, 32'h0000_0003);
    @(negedge clock);
    check("other_addr_status", status, STAT_IDLE);
    count_tx_low(20, lows);
    check("other_addr_tx", 32'(lows), 32'd0);

    // Push landing on the pop edge with one word queued.
    store(A_TX, 32'h0000_1234);
    store(A_TX, 32'h0000_C3E1);
    repeat (CPB * WB + 2 - 4) @(negedge clock);
    store(A_TX, 32'h0000_5A0F);
    rx_word(WB, got);
    check("pushpop_first", got, word_frame(8'hC3, 8'hE1));
    check("pushpop_count", {24'd0, status[7:0]}, 32'd1);
    rx_word(WB, got);
    check("pushpop_second", got, word_frame(8'h5A, 8'h0F));
    repeat (CPB + 2) @(negedge clock);
    check("pushpop_idle", status, STAT_IDLE);

`ifdef SAMPLE_TX_PARITY_EN
    store(A_TX, 32'h0000_0007);
    rx_word(WB, got);
    check("parity_line", got, 32'({1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0}));
    check("parity_flag", {31'd0, status[12]}, 32'd1);
    repeat (CPB + 2) @(negedge clock);
`endif

    // Reset in the middle of a data bit with another word queued.
    store(A_TX, 32'h0000_0000);
    store(A_TX, 32'h0000_FFFF);
    repeat (4) @(negedge clock);
    check("pre_reset_data_low", {31'd0, tx}, 32'd0);
    #1 reset = 1'b0;
    #1;
    check("midreset_tx", {31'd0, tx}, 32'd1);
    check("midreset_status", status, STAT_IDLE);
    check("midreset_full", {31'd0, fifo_full}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("post_reset_status", status, STAT_IDLE);
    count_tx_low(60, lows);
    check("post_reset_tx_high", 32'(lows), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sample_tx_stream.md
Name: sample_tx_stream

Overview:
- Memory-mapped UART transmitter that carries processed biosignal results (EMG/ECG features) off-chip.
- The ADC capture path writes into processor RAM; this block runs the other way. It snoops processor dmem store traffic, queues words written to TX_ADDR in a FIFO, and serializes them as 8N1 UART bytes on a single pin.
- Sits in the top-level wrapper beside RAM, on the processor's wren/address_dmem/data bus. The wrapper muxes status onto q_dmem for loads from STATUS_ADDR.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 2.
- TX_ADDR, 12'hC80, dmem word address whose stores are queued for transmit.
- CTRL_ADDR, 12'hC81, dmem word address for control stores.
- FIFO_DEPTH, 8, FIFO entries of 32 bits; power of two, 2..128.
- BYTES_PER_WORD, 2, low-order bytes sent per word (1..4), LSB byte first.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- wren  in  1  processor dmem write enable
- address_dmem  in  12  processor dmem word address (address_dmem[11:0])
- data  in  32  processor store data
- tx  out  1  UART serial output, idle high
- status  out  32  status word for the processor, read through the wrapper
- fifo_full  out  1  FIFO full flag

Behaviour:
- Reset (reset=0, asynchronous):
  - tx=1, FIFO emptied, status=0 except empty=1, fifo_full=0.
  - FSM returns to IDLE and overflow clears.
  - Reset mid-byte aborts the byte immediately; tx goes high without waiting for a clock edge.
- Push:
  - On an edge with wren=1, address_dmem==TX_ADDR and FIFO not full, data is written to the tail; count increments after that edge.
  - If the FIFO is full, including the case where a pop happens on the same edge, the word is dropped and overflow becomes 1 (sticky). Full is judged on pre-edge state.
- Control store (wren=1, address_dmem==CTRL_ADDR):
  - data[0]=1 clears overflow.
  - data[1]=1 flushes the FIFO. count=0 after the edge.
  - A byte or word already in the shift register completes normally.
- FSM states: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
  - IDLE: when the FIFO is non-empty, the next edge pops the head into word_reg, sets byte_idx=0 and enters START. Count decrements on the same edge; a simultaneous push still increments.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: tx = current byte's bit, LSB first. 8 bits, each held CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if byte_idx<BYTES_PER_WORD-1, byte_idx increments and the FSM enters START directly (no idle gap). Otherwise it returns to IDLE.
  - IDLE always lasts at least one cycle between words.
- Latency:
  - A store to TX_ADDR at edge k into an empty FIFO with the FSM in IDLE gives tx=0 from edge k+1.
  - One word occupies BYTES_PER_WORD*10*CLKS_PER_BIT cycles on the line, plus one IDLE cycle.
- Bit timing: a down-counter reloads to CLKS_PER_BIT-1 at each bit boundary; the bit advances when the counter reaches 0.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH. Full and empty are derived from the pointer MSB compare.
- status fields:
  - [7:0] count (zero-extended)
  - [8] full
  - [9] empty
  - [10] busy (FSM not IDLE)
  - [11] overflow
  - [31:12] = 0
  - status is registered and updates one cycle after the causing edge.
- fifo_full is combinational from the pointers.
- Stores to other addresses are ignored. The block never drives or stalls the processor bus.

Optional Feature:
- Macro: SAMPLE_TX_PARITY_EN.
- Defined: after the 8 data bits, the PARITY state drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles, giving 8E1 framing at 11 bits per byte. status[12]=1 flags that parity is compiled in.
- Undefined: the PARITY state does not exist, framing is 8N1, and status[12]=0.

Test Plan (CLKS_PER_BIT=4, BYTES_PER_WORD=2):
- Reset during traffic: assert reset=0 mid-DATA -> tx=1 immediately, status=32'h00000200, and tx stays high after release with no pending data.
- Single word: store 32'h0000A53C to 12'hC80 -> starting one edge later, tx sends start, 0x3C LSB first (0,0,1,1,1,1,0,0), stop, then start, 0xA5, stop. Each bit lasts 4 cycles, 80 cycles total. busy falls afterward.
- Fill and overflow: 9 back-to-back stores while tx is busy with an earlier word -> 8 accepted, 9th dropped. status[11]=1, fifo_full=1, count=8.
- Overflow clear and flush: store 32'h3 to 12'hC81 -> overflow=0, count=0. The in-flight byte completes intact, then the FSM goes to IDLE.
- Non-target stores: stores to 12'hC7F and 12'hC82 -> no count change, tx stays high.
- Simultaneous push and pop with count=1: the store lands on the pop edge -> count stays 1 and both words transmit in order.
- With SAMPLE_TX_PARITY_EN: store 32'h00000007 -> byte 0x07 is followed by parity bit 1 and the frame is 11 bits; byte 0x00 gets parity 0.
